// File: rtl/flash_seq_ctrl.sv
// Flash ADC channel sequencer: comparator reset/settle/latch, encoder capture, 2^AVG_LOG2-sample mean.
// Result after 2^AVG_LOG2*(SETTLE_CYC+4)+1 cycles; OUT holds result and comparators idle until dout_rdy.
module flash_seq_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int AVG_LOG2   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_cont,
  input  logic        i_abort,
  input  logic [63:0] i_therm,
  output logic        o_comp_rst,
  output logic        o_comp_lat,
  output logic [63:0] o_enc_in,
  input  logic [5:0]  i_enc_out,
  output logic [5:0]  o_dout,
  output logic        o_dout_vld,
  input  logic        i_dout_rdy,
  output logic        o_dout_bub,
  output logic        o_bub_err,
  output logic        o_busy
);

  localparam int ACC_W = 6 + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [3:0]       SETTLE_LAST = 4'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_SETTLE, S_LATCH, S_ENC, S_ACC, S_OUT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_settle_cnt;
  logic [63:0]      r_enc_in;
  logic [5:0]       r_code;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bub;
  logic             r_bub_err;
  logic [63:0]      w_enc_plus1;
  logic             w_bubble;
  logic [ACC_W-1:0] w_acc_sum;

  // A legal word 0..01..1 has no set bit in common with itself plus one.
  assign w_enc_plus1 = r_enc_in + 64'd1;
  assign w_bubble    = |(r_enc_in & w_enc_plus1);
  assign w_acc_sum   = r_acc + ACC_W'(r_code);
  assign o_enc_in    = r_enc_in;
  assign o_bub_err   = r_bub_err;

  always_comb begin
    w_state_nxt = r_state;
    o_comp_rst  = 1'b0;
    o_comp_lat  = 1'b0;
    o_dout_vld  = 1'b0;
    o_dout      = '0;
    o_dout_bub  = 1'b0;
    o_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_RST;
      S_RST: begin
        o_comp_rst  = 1'b1;
        w_state_nxt = (SETTLE_CYC == 0) ? S_LATCH : S_SETTLE;
      end
      S_SETTLE: if (r_settle_cnt == SETTLE_LAST) w_state_nxt = S_LATCH;
      S_LATCH: begin
        o_comp_lat  = 1'b1;
        w_state_nxt = S_ENC;
      end
      S_ENC:    w_state_nxt = S_ACC;
      S_ACC:    w_state_nxt = (r_cnt == CNT_LAST) ? S_OUT : S_RST;
      S_OUT: begin
        o_dout_vld = 1'b1;
        o_dout     = r_acc[ACC_W-1 -: 6];
        o_dout_bub = r_bub;
        if (i_dout_rdy) w_state_nxt = i_cont ? S_RST : S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
    if (i_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_enc_in     <= '0;
      r_code       <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_bub        <= 1'b0;
      r_bub_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (i_abort) begin
        // Sticky bub_err survives an abort; the partial result does not.
        r_acc <= '0;
        r_cnt <= '0;
        r_bub <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (i_start) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_bub     <= 1'b0;
            r_bub_err <= 1'b0;
          end
          S_RST:    r_settle_cnt <= '0;
          S_SETTLE: r_settle_cnt <= r_settle_cnt + 4'd1;
          S_LATCH:  r_enc_in <= i_therm;
          S_ENC: begin
            r_code <= i_enc_out;
            if (w_bubble) begin
              r_bub     <= 1'b1;
              r_bub_err <= 1'b1;
            end
          end
          S_ACC: begin
            r_acc <= w_acc_sum;
            if (r_cnt != CNT_LAST) r_cnt <= r_cnt + CNT_W'(1);
          end
          S_OUT: if (i_dout_rdy && i_cont) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_bub <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/flash_seq_ctrl.md
Name: flash_seq_ctrl

Overview:
- Sequences one 64-comparator flash ADC conversion channel.
- Drives the comparator reset and latch phases, then captures the 64-bit thermometer word.
- Presents the captured word to the external 64-to-6 fat-tree thermometer encoder and samples its 6-bit code.
- Averages 2^AVG_LOG2 codes and returns the mean over a valid/ready handshake, in single-shot or continuous mode, with thermometer bubble detection.

Parameters:
- SETTLE_CYC, 2, comparator settle cycles between reset release and latch; legal range 0..15, 0 skips the SETTLE state.
- AVG_LOG2, 2, log2 of samples averaged per result; legal range 0..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a conversion; sampled in IDLE only.
- cont  in  1  continuous mode; sampled at each OUT handshake.
- abort  in  1  synchronous abort to IDLE.
- therm  in  64  comparator thermometer outputs; bit0 = lowest threshold.
- comp_rst  out  1  comparator reset phase.
- comp_lat  out  1  comparator latch strobe.
- enc_in  out  64  registered thermometer word to the fat-tree encoder.
- enc_out  in  6  encoder result; combinational from enc_in.
- dout  out  6  averaged code.
- dout_vld  out  1  result valid.
- dout_rdy  in  1  consumer ready.
- dout_bub  out  1  a bubble occurred within this result's samples.
- bub_err  out  1  sticky bubble flag.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - comp_rst, comp_lat, dout_vld, dout_bub, bub_err and busy are 0.
  - enc_in, dout, the accumulator (6+AVG_LOG2 bits) and the sample counter (AVG_LOG2 bits) are 0.
  - Reset overrides abort, and abort overrides start.
- States: IDLE, RST, SETTLE, LATCH, ENC, ACC, OUT.
- IDLE:
  - start=1 moves to RST, clears the accumulator, the counter and bub_err.
  - start is ignored in every other state.
- RST: comp_rst=1 for 1 cycle. Next state is SETTLE, or LATCH if SETTLE_CYC=0.
- SETTLE:
  - Stays for exactly SETTLE_CYC cycles; comp_rst=0 and comp_lat=0.
  - Moves to LATCH.
- LATCH:
  - comp_lat=1 for 1 cycle.
  - At the end of the cycle, enc_in<=therm.
  - Moves to ENC.
- ENC:
  - enc_in is held.
  - At the end of the cycle, an internal code register <= enc_out.
  - Bubble check on enc_in: the word is legal only if it has the form 0..01..1 (all-zero and all-one are legal).
  - An illegal word sets bub_err and the per-result bubble bit.
  - Moves to ACC.
- ACC:
  - acc<=acc+code, with no overflow possible at these widths.
  - If the counter equals 2^AVG_LOG2-1, move to OUT. Otherwise increment the counter and move to RST.
- OUT:
  - dout=acc[AVG_LOG2+5:AVG_LOG2] (truncating mean).
  - dout_vld=1; dout_bub = the per-result bubble bit.
  - Holds with dout, dout_vld and dout_bub stable until dout_rdy=1.
  - On a handshake cycle (dout_vld & dout_rdy):
    - if cont=1, clear acc, counter and per-result bubble, then go to RST;
    - else go to IDLE.
  - No comparator activity while stalled.
  - dout_vld drops the cycle after the handshake.
- Timing:
  - Per sample: SETTLE_CYC+4 cycles.
  - Start seen at cycle 0 gives dout_vld first high at cycle 2^AVG_LOG2*(SETTLE_CYC+4)+1. At defaults this is cycle 25.
- cont:
  - Deasserting cont mid-conversion still completes the current result, then returns to IDLE.
  - cont is read only at the handshake.
- abort=1 in any state:
  - Next state is IDLE.
  - comp_rst, comp_lat and dout_vld go to 0 next cycle.
  - acc and counter are cleared; bub_err is retained.
  - A result pending in OUT is discarded.
- therm is sampled only in LATCH; changes at other times have no effect.
- enc_in is never changed outside LATCH.

Test Plan:
1. Defaults; therm=64'h0000_0000_FFFF_FFFF held; encoder model returns 32; pulse start with cont=0, dout_rdy=1 -> comp_lat pulses 4 times, 6 cycles apart; dout=32, dout_vld high exactly at cycle 25 for 1 cycle; dout_bub=0; busy drops next cycle.
2. Codes across the 4 samples are 10, 11, 11, 13 (sum 45) -> dout=11 (truncated); SETTLE_CYC=0 build gives dout_vld at cycle 17.
3. dout_rdy=0 for 10 cycles in OUT -> dout, dout_vld and dout_bub held stable with no comp_rst/comp_lat; with cont=1 at the handshake, comp_rst rises the cycle after the handshake.
4. Second sample latches therm=64'h0000_0000_0000_00F5 -> dout_bub=1 on that result and bub_err=1 until the next start; a following clean conversion in cont mode gives dout_bub=0 while bub_err stays 1.
5. abort asserted during SETTLE of sample 3 -> IDLE next cycle, comp_rst=0, comp_lat=0, no dout_vld; a new start gives a full 25-cycle conversion whose mean excludes the aborted samples.
6. rst_n low for 1 cycle while in OUT with dout_vld=1 -> all outputs 0 next cycle; start asserted during busy is ignored (no restart, same completion cycle).
